// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight E/M/W destinations and drives E forwarding selects, PC/IF-ID stall, IF-ID/ID-EX/EX-MEM flushes and saturating stall/flush counters (clk, async active-low reset, D-stage fields in, pcsrc_m in)
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic [ADDR_W-1:0] dst_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              pcsrc_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic e_v, e_urs, e_urt, e_rw, e_mr, m_v, m_rw, w_v, w_rw;
  logic [ADDR_W-1:0] e_rs, e_rt, e_dst, m_dst, w_dst;
  logic hz_e, hz_m, hz_w, stall;
  function automatic logic hit(input logic v, input logic rw, input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] r);
    return v & rw & (dst == r) & (|r);
  endfunction
  assign hz_e = valid_d & ((use_rs_d & hit(e_v, e_rw, e_dst, rs_d)) | (use_rt_d & hit(e_v, e_rw, e_dst, rt_d)));
  assign hz_m = valid_d & ((use_rs_d & hit(m_v, m_rw, m_dst, rs_d)) | (use_rt_d & hit(m_v, m_rw, m_dst, rt_d)));
  assign hz_w = valid_d & ((use_rs_d & hit(w_v, w_rw, w_dst, rs_d)) | (use_rt_d & hit(w_v, w_rw, w_dst, rt_d)));
  assign stall   = (FWD_EN != 0) ? (hz_e & e_mr) : (hz_e | hz_m | hz_w);
  assign stall_f = stall & ~pcsrc_m;
  assign stall_d = stall & ~pcsrc_m;
  assign flush_d = pcsrc_m;
  assign flush_e = stall | pcsrc_m;
  assign flush_m = pcsrc_m;
  assign fwd_a_e = (FWD_EN == 0 || !e_urs) ? 2'b00 :
                   hit(m_v, m_rw, m_dst, e_rs) ? 2'b10 :
                   hit(w_v, w_rw, w_dst, e_rs) ? 2'b01 : 2'b00;
  assign fwd_b_e = (FWD_EN == 0 || !e_urt) ? 2'b00 :
                   hit(m_v, m_rw, m_dst, e_rt) ? 2'b10 :
                   hit(w_v, w_rw, w_dst, e_rt) ? 2'b01 : 2'b00;
  // an E bubble also clears its use/write bits so it can neither forward nor hazard
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {e_v, e_urs, e_urt, e_rw, e_mr, m_v, m_rw, w_v, w_rw} <= '0;
      {e_rs, e_rt, e_dst, m_dst, w_dst} <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      w_v   <= m_v;
      w_rw  <= m_rw;
      w_dst <= m_dst;
      m_v   <= e_v & ~pcsrc_m;
      m_rw  <= e_rw;
      m_dst <= e_dst;
      e_v   <= valid_d & ~flush_e;
      e_urs <= use_rs_d & ~flush_e;
      e_urt <= use_rt_d & ~flush_e;
      e_rw  <= regwrite_d & ~flush_e;
      e_mr  <= memtoreg_d & ~flush_e;
      e_rs  <= rs_d;
      e_rt  <= rt_d;
      e_dst <= dst_d;
      if (stall_d && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (pcsrc_m && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: checks a forwarding/16-bit-counter instance and a stall-only/2-bit-counter instance against a stage-array model
module tb_hazard_ctrl;
  logic clk = 0, reset = 0;
  logic valid_d, use_rs_d, use_rt_d, regwrite_d, memtoreg_d, pcsrc_m;
  logic [4:0] rs_d, rt_d, dst_d;
  logic a_sf, a_sd, a_fd, a_fe, a_fm, b_sf, b_sd, b_fd, b_fe, b_fm;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [15:0] a_sc, a_fc;
  logic [1:0] b_sc, b_fc;
  logic [8:0] a_out, b_out;
  assign a_out = {a_sf, a_sd, a_fd, a_fe, a_fm, a_fa, a_fb};
  assign b_out = {b_sf, b_sd, b_fd, b_fe, b_fm, b_fa, b_fb};
  always #5 clk = ~clk;
  hazard_ctrl #(.ADDR_W(5), .FWD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .dst_d(dst_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .pcsrc_m(pcsrc_m), .stall_f(a_sf), .stall_d(a_sd),
    .flush_d(a_fd), .flush_e(a_fe), .flush_m(a_fm), .fwd_a_e(a_fa), .fwd_b_e(a_fb),
    .stall_cnt(a_sc), .flush_cnt(a_fc));
  hazard_ctrl #(.ADDR_W(5), .FWD_EN(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .dst_d(dst_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .pcsrc_m(pcsrc_m), .stall_f(b_sf), .stall_d(b_sd),
    .flush_d(b_fd), .flush_e(b_fe), .flush_m(b_fm), .fwd_a_e(b_fa), .fwd_b_e(b_fb),
    .stall_cnt(b_sc), .flush_cnt(b_fc));
  typedef struct packed {logic v; logic [4:0] rs, rt; logic urs, urt; logic [4:0] dst; logic rw, mr;} ins_t;
  typedef struct {ins_t d; logic p; logic [8:0] ea;} vec_t;
  ins_t pe[2][3];
  int sc[2], fc[2];
  int n_chk = 0, n_fail = 0;
  ins_t cur;
  logic p;
  vec_t tv[16];
  function automatic ins_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic [4:0] dst, logic rw, logic mr);
    return {v, rs, rt, urs, urt, dst, rw, mr};
  endfunction
  function automatic bit mt(ins_t s, logic [4:0] r);
    return s.v && s.rw && s.dst == r && r != 0;
  endfunction
  function automatic bit hz(ins_t s);
    return cur.v && ((cur.urs && mt(s, cur.rs)) || (cur.urt && mt(s, cur.rt)));
  endfunction
  function automatic bit stl(int i);
    return (i == 0) ? (hz(pe[i][0]) && pe[i][0].mr) : (hz(pe[i][0]) || hz(pe[i][1]) || hz(pe[i][2]));
  endfunction
  function automatic logic [1:0] fw(int i, logic u, logic [4:0] r);
    if (i == 1 || !u) return 2'b00;
    if (mt(pe[i][1], r)) return 2'b10;
    if (mt(pe[i][2], r)) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [8:0] exp_out(int i);
    bit s = stl(i);
    bit sd = s && !p;
    return {sd, sd, p, s || p, p, fw(i, pe[i][0].urs, pe[i][0].rs), fw(i, pe[i][0].urt, pe[i][0].rt)};
  endfunction
  function automatic int sat(int v, int m);
    return v > m ? m : v;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(ins_t x, logic pc);
    cur = x; p = pc;
    valid_d = x.v; rs_d = x.rs; rt_d = x.rt; use_rs_d = x.urs; use_rt_d = x.urt;
    dst_d = x.dst; regwrite_d = x.rw; memtoreg_d = x.mr; pcsrc_m = pc;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) pe[i][j] = '0;
      sc[i] = 0; fc[i] = 0;
    end
  endtask
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit s = stl(i);
      if (s && !p) sc[i]++;
      if (p) fc[i]++;
      pe[i][2] = pe[i][1];
      pe[i][1] = p ? '0 : pe[i][0];
      pe[i][0] = (s || p) ? '0 : cur;
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("out_a", 32'(a_out), 32'(exp_out(0)));
    chk("out_b", 32'(b_out), 32'(exp_out(1)));
    chk("scnt_a", 32'(a_sc), 32'(sat(sc[0], 65535)));
    chk("fcnt_a", 32'(a_fc), 32'(sat(fc[0], 65535)));
    chk("scnt_b", 32'(b_sc), 32'(sat(sc[1], 3)));
    chk("fcnt_b", 32'(b_fc), 32'(sat(fc[1], 3)));
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    ins_t nop, x;
    nop = '0;
    tv[0]  = '{mk(1, 1, 2, 1, 1, 3, 1, 0), 1'b0, 9'h000};
    tv[1]  = '{mk(1, 3, 1, 1, 1, 4, 1, 0), 1'b0, 9'h000};
    tv[2]  = '{mk(1, 5, 3, 1, 1, 6, 1, 0), 1'b0, 9'h008};
    tv[3]  = '{nop,                        1'b0, 9'h001};
    tv[4]  = '{mk(1, 1, 0, 1, 0, 5, 1, 1), 1'b0, 9'h000};
    tv[5]  = '{mk(1, 5, 5, 1, 1, 7, 1, 0), 1'b0, 9'h1A0};
    tv[6]  = '{mk(1, 5, 5, 1, 1, 7, 1, 0), 1'b0, 9'h000};
    tv[7]  = '{nop,                        1'b0, 9'h005};
    tv[8]  = '{mk(1, 0, 0, 1, 1, 0, 1, 0), 1'b0, 9'h000};
    tv[9]  = '{mk(1, 0, 0, 1, 1, 8, 1, 0), 1'b0, 9'h000};
    tv[10] = '{nop,                        1'b0, 9'h000};
    tv[11] = '{nop,                        1'b0, 9'h000};
    tv[12] = '{mk(1, 0, 0, 0, 0, 9, 1, 1), 1'b0, 9'h000};
    tv[13] = '{mk(1, 9, 0, 1, 1, 10, 1, 0), 1'b1, 9'h070};
    tv[14] = '{nop,                        1'b0, 9'h000};
    tv[15] = '{nop,                        1'b0, 9'h000};
    model_reset();
    drive(nop, 0);
    repeat (2) cyc();
    reset = 1;
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].d, tv[i].p);
      #1 chk($sformatf("vec%0d_a", i), 32'(a_out), 32'(tv[i].ea));
      cyc();
    end
    chk("loaduse_scnt_a", 32'(a_sc), 32'd1);
    chk("flush_fcnt_a", 32'(a_fc), 32'd1);
    reset = 0;
    model_reset();
    drive(nop, 0);
    cyc();
    reset = 1;
    drive(mk(1, 1, 1, 1, 1, 2, 1, 0), 0);
    cyc();
    drive(mk(1, 2, 2, 1, 1, 3, 1, 0), 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("nofwd_stall_b", 32'(b_sd), 32'(k < 3));
      chk("nofwd_fwd_b", 32'({b_fa, b_fb}), 32'd0);
      cyc();
    end
    chk("nofwd_scnt_b", 32'(b_sc), 32'd3);
    drive(mk(1, 3, 3, 1, 1, 4, 1, 0), 0);
    repeat (2) cyc();
    #1 chk("sat_scnt_b", 32'(b_sc), 32'd3);
    chk("sat_stall_b", 32'(b_sd), 32'd1);
    reset = 0;
    #1 chk("rst_out_a", 32'(a_out), 32'd0);
    chk("rst_out_b", 32'(b_out), 32'd0);
    chk("rst_cnt_a", 32'({a_sc, a_fc}), 32'd0);
    chk("rst_cnt_b", 32'({b_sc, b_fc}), 32'd0);
    model_reset();
    cyc();
    reset = 1;
    for (int n = 0; n < 3000; n++) begin
      x = mk(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      drive(x, 1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 199) == 0) begin
        reset = 0;
        model_reset();
        cyc();
        reset = 1;
      end else cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
